mmio_arbiter: RTL
=================

// Module: mmio_arbiter
// PURPOSE
//  2:1 request arbiter directly upstream of the mmio block. Merges fetch (m0)
//  and load/store (m1) requests onto the single valid/ready bus into mmio.
//  Latches the winning request, holds it until mmio's ready strobe, then routes
//  the read data and completion back to the winning master.
// PARAMETERS
//  TIMEOUT_CYCLES  255  s_ready wait limit in cycles; used only with MMIO_ARB_TIMEOUT_EN; range 1..65535
// PORTS
//  clk        in   1   clock, all logic on rising edge
//  reset      in   1   synchronous, active-low reset
//  m0_valid   in   1   fetch request; held high with payload stable until m0_ready
//  m0_ready   out  1   one-cycle completion strobe to fetch
//  m0_addr    in   32  fetch address
//  m0_dtw     in   32  fetch write data (normally unused)
//  m0_dtr     out  32  read data to fetch; valid only while m0_ready=1
//  m0_rw      in   1   1=write, 0=read
//  m1_*       -    -   same as m0_*, load/store master
//  s_valid    out  1   request to mmio (registered)
//  s_ready    in   1   completion strobe from mmio
//  s_addr     out  32  latched address (registered)
//  s_dtw      out  32  latched write data (registered)
//  s_dtr      in   32  read data from mmio; valid while s_ready=1
//  s_rw       out  1   latched direction (registered)
//  s_err      out  1   one-cycle timeout strobe; tied 0 without MMIO_ARB_TIMEOUT_EN
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, last=0, s_valid=0, s_addr=0,
//    s_dtw=0, s_rw=0, s_err=0, timeout counter=0. Aborts any in-flight request;
//    no ready strobe is issued for it. m*_ready are 0 while state=IDLE.
//  - FSM: IDLE, BUSY0, BUSY1.
//  - IDLE: only m0_valid -> BUSY0; only m1_valid -> BUSY1; both -> round-robin:
//    grant master != last. On grant, same edge: s_valid<=1, latch addr/dtw/rw
//    of the winner into s_*, last<=winner. Neither valid -> stay IDLE.
//  - BUSY n: s_* held constant. mN_ready = s_ready (combinational), other
//    master's ready=0. mN_dtr = s_dtr; non-granted dtr=0. On s_ready=1 at
//    posedge: s_valid<=0, state<=IDLE.
//  - Latency: request seen in IDLE at edge E -> s_valid high after E. Ready
//    pass-through is 0 cycles. Min cycles IDLE->IDLE per transaction is
//    2 + mmio wait. Back-to-back requests always pass through one IDLE cycle.
//  - Masters must drop valid the cycle after their ready. A valid still high in
//    IDLE is a new request.
//  - Valid changes from a non-granted master while BUSY are ignored. It is
//    arbitrated at the next IDLE.
//  - s_ready while IDLE is ignored.
//  - Payload changes on a master while it is granted have no effect (latched).
// CONFIGURATION
//  MMIO_ARB_TIMEOUT_EN defined:
//    - 16-bit counter clears on grant and increments each BUSY cycle with s_ready=0.
//    - At count==TIMEOUT_CYCLES-1 with s_ready still 0, in the same cycle:
//      mN_ready=1, mN_dtr=32'hFFFF_FFFF, s_err=1.
//    - Next edge: s_valid<=0, state<=IDLE.
//    - s_ready in that same cycle wins: normal completion, s_err=0.
//  MMIO_ARB_TIMEOUT_EN undefined: no counter. BUSY waits forever. s_err=0.
// TESTING
//  - Reset: hold reset=0 for 2 clk with m0_valid=1 -> s_valid=0, m0_ready=0,
//    state IDLE. Release reset -> s_valid=1 one clk later, s_addr=m0_addr.
//  - Single read: m1 rd addr=0x0000_1000. mmio returns s_ready after 3 cycles
//    with s_dtr=0xDEAD_BEEF -> m1_ready 1 clk, m1_dtr=0xDEAD_BEEF, m0_ready=0.
//  - Contention: m0 and m1 both valid from reset -> m1 served first (last=0).
//    Both re-request -> m0 next, then m1: strict alternation over 6 requests.
//  - Write latch: m0 wr addr=0x10, dtw=0x1234_5678, rw=1. Change m0_addr while
//    BUSY -> s_addr/s_dtw/s_rw unchanged until ready. s_valid low the cycle after s_ready.
//  - Reset mid-op: assert reset while BUSY1 with s_ready=0 -> next clk s_valid=0,
//    IDLE, m1_ready never pulses. Pending m0 is then served first (last=0).
//  - Timeout (MMIO_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): s_ready never asserted ->
//    4th BUSY cycle: m0_ready=1, m0_dtr=FFFF_FFFF, s_err=1. Then IDLE.

Source files
------------

// File: rtl/mmio_arbiter.sv
// 2:1 round-robin arbiter that merges fetch (m0) and load/store (m1) requests onto the mmio bus.
// Optional s_ready timeout is enabled by defining MMIO_ARB_TIMEOUT_EN.
module mmio_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_dtw,
    output logic [31:0] m0_dtr,
    input  logic        m0_rw,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_dtw,
    output logic [31:0] m1_dtr,
    input  logic        m1_rw,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_dtw,
    input  logic [31:0] s_dtr,
    output logic        s_rw,
    output logic        s_err
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;
    logic            r_s_valid;
    logic [AW-1:0]   r_s_addr;
    logic [DW-1:0]   r_s_dtw;
    logic            r_s_rw;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_done;
    logic            w_timeout;

    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mmio_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

`ifdef MMIO_ARB_TIMEOUT_EN
    logic [CW-1:0] r_tmo_cnt;

    // w_timeout already excludes s_ready, so a late s_ready still completes normally
    assign w_timeout = (r_state != IDLE) && !s_ready &&
                       (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
        end else if (w_grant0 || w_grant1) begin
            r_tmo_cnt <= '0;
        end else if ((r_state != IDLE) && !s_ready) begin
            r_tmo_cnt <= r_tmo_cnt + CW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant0    = 1'b0;
        w_grant1    = 1'b0;
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        m0_dtr      = '0;
        m1_dtr      = '0;
        s_err       = 1'b0;
        unique case (r_state)
            IDLE: begin
                // On contention the master that did not win last time is granted
                if (m0_valid && m1_valid) begin
                    w_grant0 = r_last;
                    w_grant1 = !r_last;
                end else begin
                    w_grant0 = m0_valid;
                    w_grant1 = m1_valid;
                end
                if (w_grant0) begin
                    w_state_nxt = BUSY0;
                end else if (w_grant1) begin
                    w_state_nxt = BUSY1;
                end
            end
            BUSY0: begin
                m0_ready = s_ready || w_timeout;
                m0_dtr   = w_timeout ? '1 : s_dtr;
                s_err    = w_timeout;
                if (m0_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY1: begin
                m1_ready = s_ready || w_timeout;
                m1_dtr   = w_timeout ? '1 : s_dtr;
                s_err    = w_timeout;
                if (m1_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_done = m0_ready || m1_ready;

    // Winner's payload is latched at grant and held until completion
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last    <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_addr  <= '0;
            r_s_dtw   <= '0;
            r_s_rw    <= 1'b0;
        end else if (w_grant0) begin
            r_last    <= 1'b0;
            r_s_valid <= 1'b1;
            r_s_addr  <= m0_addr;
            r_s_dtw   <= m0_dtw;
            r_s_rw    <= m0_rw;
        end else if (w_grant1) begin
            r_last    <= 1'b1;
            r_s_valid <= 1'b1;
            r_s_addr  <= m1_addr;
            r_s_dtw   <= m1_dtw;
            r_s_rw    <= m1_rw;
        end else if (w_done) begin
            r_s_valid <= 1'b0;
        end
    end

    assign s_valid = r_s_valid;
    assign s_addr  = r_s_addr;
    assign s_dtw   = r_s_dtw;
    assign s_rw    = r_s_rw;

endmodule
